// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [PC_W-1:0]   RESET_PC_DEF = 32'h0100_0000;
  localparam logic [INST_W-1:0] NOP          = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] data;
    logic              full;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue_buf.sv
// Ring of fetch entries: allocated at request accept, filled in order by responses, popped by decode.
module fetch_queue_buf import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [PC_W-1:0]          alloc_pc,
  input  logic                     fill_en,
  input  logic [INST_W-1:0]        fill_data,
  input  logic                     pop_en,
  output logic [PC_W-1:0]          head_pc,
  output logic [INST_W-1:0]        head_data,
  output logic                     head_full,
  output logic [$clog2(DEPTH):0]   alloc_cnt,
  output logic [$clog2(DEPTH):0]   pending_cnt
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t ent [DEPTH];
  logic [PW:0]  head, fill, tail;

  // Pointers carry a wrap bit so full (DEPTH) and empty (0) are distinguishable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      fill <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      head <= '0;
      fill <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].full <= 1'b0;
    end else begin
      if (alloc_en) begin
        ent[tail[PW-1:0]].pc <= alloc_pc;
        tail <= tail + (PW+1)'(1);
      end
      if (fill_en) begin
        ent[fill[PW-1:0]].data <= fill_data;
        ent[fill[PW-1:0]].full <= 1'b1;
        fill <= fill + (PW+1)'(1);
      end
      if (pop_en) begin
        ent[head[PW-1:0]].full <= 1'b0;
        head <= head + (PW+1)'(1);
      end
    end
  end

  assign head_pc     = ent[head[PW-1:0]].pc;
  assign head_data   = ent[head[PW-1:0]].data;
  assign head_full   = ent[head[PW-1:0]].full;
  assign alloc_cnt   = tail - head;
  assign pending_cnt = tail - fill;
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, in-order response queue, redirect flush.
// Optional FETCH_QUEUE_STATS_EN adds stat_fetched / stat_flushes counters.
module fetch_queue import fetch_pkg::*; #(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INST_W-1:0]  imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INST_W-1:0]  inst_data,
  output logic [PC_W-1:0]    inst_pc
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_flushes
`endif
);
  localparam int AW = $clog2(DEPTH) + 1;

  logic            run;
  logic [PC_W-1:0] fetch_pc;
  logic [AW-1:0]   drop_cnt, drop_next;
  logic [AW-1:0]   alloc_cnt, pending_cnt;
  logic [AW:0]     outst, drop_sum;
  logic            req_accept, rsp_live, rsp_drop, pop;
  logic            redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Requests are held off until the first clock after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run <= 1'b0;
    else          run <= 1'b1;
  end

  assign imem_req_valid = run && (alloc_cnt < AW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign pop            = inst_valid && inst_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_live       = imem_rsp_valid && (drop_cnt == '0) && (pending_cnt != '0) && !redirect_valid;

  // On redirect every response still owed by memory must be discarded.
  always_comb begin
    outst     = {1'b0, drop_cnt} + {1'b0, pending_cnt};
    drop_sum  = outst + {{AW{1'b0}}, req_accept}
                      - {{AW{1'b0}}, (imem_rsp_valid && outst != '0)};
    drop_next = (drop_sum > (AW+1)'(DEPTH)) ? AW'(DEPTH) : drop_sum[AW-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
      drop_cnt <= drop_next;
    end else begin
      if (req_accept) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_drop)   drop_cnt <= drop_cnt - AW'(1);
    end
  end

  fetch_queue_buf #(.DEPTH(DEPTH)) u_buf (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (redirect_valid),
    .alloc_en    (req_accept),
    .alloc_pc    (fetch_pc),
    .fill_en     (rsp_live),
    .fill_data   (imem_rsp_data),
    .pop_en      (pop),
    .head_pc     (inst_pc),
    .head_data   (inst_data),
    .head_full   (inst_valid),
    .alloc_cnt   (alloc_cnt),
    .pending_cnt (pending_cnt)
  );

`ifdef FETCH_QUEUE_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else begin
      stat_fetched <= stat_fetched + 32'(pop);
      stat_flushes <= stat_flushes + 32'(redirect_valid);
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clock)
    if (reset_n && imem_rsp_valid)
      assert (drop_cnt != '0 || pending_cnt != '0);
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: epoch/queue model of fetch order plus a fixed-latency memory.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0100_0000;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetched, stat_flushes;
`endif

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_QUEUE_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes)
`endif
  );

  typedef struct { logic [31:0] pc; bit arrived; } ment_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ment_t       mq[$];
  mreq_t       pending[$];
  logic [31:0] seen[$];
  logic [31:0] mpc, prev_addr, last_acc;
  int          dead, lat, mcyc, rc, first_valid, acc_cnt, hs_cnt, flush_cnt;
  bit          started, stall_prev;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] seen_at(input int i);
    if (i < seen.size()) return seen[i];
    return 32'hxxxx_xxxx;
  endfunction

  // Memory: returns each accepted request after `lat` cycles, in order.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mcyc = 0;
    forever begin
      @(posedge clock);
      mcyc++;
      #1;
      if (!reset_n) begin
        pending.delete();
        imem_rsp_valid = 1'b0;
      end else if (pending.size() > 0 && pending[0].due <= mcyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(pending[0].addr);
        void'(pending.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Model check and update, once per cycle on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      mq.delete(); seen.delete();
      mpc = RPC; dead = 0; started = 0; stall_prev = 0;
      rc = -2; first_valid = -1; acc_cnt = 0; hs_cnt = 0; flush_cnt = 0;
    end else begin
      bit exp_rv, exp_iv, acc, pop;
      rc++;
      exp_rv = started && (mq.size() < DEPTH);
      exp_iv = (mq.size() > 0) && mq[0].arrived;
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) chk("req_addr", imem_req_addr, mpc);
      if (stall_prev) begin
        chk("hold_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("hold_addr", imem_req_addr, prev_addr);
      end
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
      if (exp_iv) begin
        chk("inst_pc", inst_pc, mq[0].pc);
        chk("inst_data", inst_data, memf(mq[0].pc));
      end
      if (inst_valid && first_valid < 0) first_valid = rc;

      acc = exp_rv && imem_req_ready;
      pop = exp_iv && inst_ready;
      if (pop) begin seen.push_back(mq[0].pc); hs_cnt++; end
      if (imem_rsp_valid) begin
        if (dead > 0) dead--;
        else begin
          for (int i = 0; i < mq.size(); i++)
            if (!mq[i].arrived) begin mq[i].arrived = 1; break; end
        end
      end
      if (acc) begin
        mq.push_back('{pc: mpc, arrived: 0});
        pending.push_back('{addr: mpc, due: mcyc + lat});
        acc_cnt++; last_acc = mpc;
      end
      if (pop) void'(mq.pop_front());
      stall_prev = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr  = imem_req_addr;
      if (redirect_valid) begin
        foreach (mq[i]) if (!mq[i].arrived) dead++;
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
        flush_cnt++;
      end else if (acc) mpc = mpc + 32'd4;
      started = 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t, output int idx);
    redirect_valid = 1'b1; redirect_pc = t;
    cycles(1);
    redirect_valid = 1'b0;
    idx = seen.size();
  endtask

  initial begin
    int idx;
    bit found;
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; lat = 1;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;

    // decode stalled: queue fills to DEPTH, then one pop lets the 5th request out
    cycles(10);
    chk("t2_accepts", acc_cnt, 4);
    chk("t2_req_off", {31'b0, imem_req_valid}, 32'd0);
    chk("t1_first_valid_cycle", first_valid, 2);
    inst_ready = 1'b1; cycles(1); inst_ready = 1'b0;
    cycles(3);
    chk("t2_accepts_after_pop", acc_cnt, 5);
    chk("t2_fifth_addr", last_acc, 32'h0100_0010);

    inst_ready = 1'b1;
    cycles(12);
    chk("t1_seen0", seen_at(0), 32'h0100_0000);
    chk("t1_seen1", seen_at(1), 32'h0100_0004);
    chk("t1_seen4", seen_at(4), 32'h0100_0010);

    // redirect with two responses in flight
    lat = 2; cycles(6);
    do_redirect(32'h0100_0103, idx);
    cycles(10);
    chk("t3_target_pc", seen_at(idx), 32'h0100_0100);
    chk("t3_target_data", memf(seen_at(idx)), 32'hFEFF_0113);

    // redirect in a cycle with both a request accept and a response
    lat = 3; cycles(8);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clock); #2;
      found = imem_req_valid && imem_req_ready && imem_rsp_valid;
    end
    chk("t4_collision_found", {31'b0, found}, 32'd1);
    do_redirect(32'h0100_0200, idx);
    cycles(14);
    chk("t4_target_pc", seen_at(idx), 32'h0100_0200);

    // random memory backpressure and decode stalls
    lat = 1;
    for (int k = 0; k < 60; k++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready     = ($urandom_range(0, 3) != 0);
      cycles(1);
    end
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    cycles(10);
`ifdef FETCH_QUEUE_STATS_EN
    chk("stat_fetched", stat_fetched, hs_cnt);
    chk("stat_flushes", stat_flushes, flush_cnt);
`endif

    // asynchronous reset in the middle of a cycle
    @(posedge clock); #3 reset_n = 1'b0;
    #1;
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_req_addr", imem_req_addr, 32'h0100_0000);
    chk("t6_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_inst_pc", inst_pc, 32'd0);
    chk("t6_inst_data", inst_data, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
    chk("t6_stat_fetched", stat_fetched, 32'd0);
    chk("t6_stat_flushes", stat_flushes, 32'd0);
`endif
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    cycles(10);
    chk("t6_refetch0", seen_at(0), 32'h0100_0000);
    chk("t6_refetch1", seen_at(1), 32'h0100_0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
